// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the register file, ROB and reservation station.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int ROB_ID_W   = 5;
    localparam int REG_ADDR_W = 5;

    typedef logic [ROB_ID_W-1:0]   rob_id_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Tag 0 marks a register with no in-flight producer; real ROB ids are 1..31.
    localparam rob_id_t ROB_ID_NONE = '0;

endpackage

// File: rtl/register_file_if.sv
// ROB <-> register file bus: launch (rename), commit (retire), flush and two operand queries.
// Latency: queries are combinational; launch/commit take effect on the next clock edge.
// Backpressure: none; every asserted launch or commit is accepted in its cycle.
// Modports: master = ROB side (drives launch/commit/query), slave = register file.
interface register_file_if #(
    parameter int XLEN     = cpu_pkg::XLEN,
    parameter int ROB_ID_W = cpu_pkg::ROB_ID_W
);
    import cpu_pkg::*;

    logic                _clear;
    logic                _rf_launch_ready;
    logic [ROB_ID_W-1:0] _rf_launch_rob_id;
    reg_addr_t           _rf_launch_register_id;
    logic                _rf_commit_ready;
    logic [ROB_ID_W-1:0] _rf_commit_rob_id;
    reg_addr_t           _rf_commit_register_id;
    logic [XLEN-1:0]     _rf_commit_value;
    reg_addr_t           _ask_rd_1;
    reg_addr_t           _ask_rd_2;
    logic [ROB_ID_W-1:0] _dep_rd_1;
    logic [ROB_ID_W-1:0] _dep_rd_2;
    logic [XLEN-1:0]     _dep_value_1;
    logic [XLEN-1:0]     _dep_value_2;

    modport master (
        output _clear,
        output _rf_launch_ready, _rf_launch_rob_id, _rf_launch_register_id,
        output _rf_commit_ready, _rf_commit_rob_id, _rf_commit_register_id, _rf_commit_value,
        output _ask_rd_1, _ask_rd_2,
        input  _dep_rd_1, _dep_rd_2, _dep_value_1, _dep_value_2
    );

    modport slave (
        input  _clear,
        input  _rf_launch_ready, _rf_launch_rob_id, _rf_launch_register_id,
        input  _rf_commit_ready, _rf_commit_rob_id, _rf_commit_register_id, _rf_commit_value,
        input  _ask_rd_1, _ask_rd_2,
        output _dep_rd_1, _dep_rd_2, _dep_value_1, _dep_value_2
    );

endinterface

// File: rtl/regfile_read_port.sv
// One operand query port: forces x0 to (dep 0, value 0) and optionally bypasses a same-cycle commit.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: ask_dat (queried reg), st_dep/st_value (stored entry for ask_dat), cmt_* (this cycle's
// effective commit), dep_dat/value_dat (answer). Bypass built only with REGFILE_COMMIT_BYPASS_EN.
module regfile_read_port #(
    parameter int XLEN     = cpu_pkg::XLEN,
    parameter int ROB_ID_W = cpu_pkg::ROB_ID_W
) (
    input  cpu_pkg::reg_addr_t   ask_dat,
    input  logic [ROB_ID_W-1:0]  st_dep,
    input  logic [XLEN-1:0]      st_value,
    input  logic                 cmt_vld,
    input  cpu_pkg::reg_addr_t   cmt_reg,
    input  logic [ROB_ID_W-1:0]  cmt_rob,
    input  logic [XLEN-1:0]      cmt_value,
    output logic [ROB_ID_W-1:0]  dep_dat,
    output logic [XLEN-1:0]      value_dat
);
    import cpu_pkg::*;

`ifdef REGFILE_COMMIT_BYPASS_EN
    logic byp_hit;

    // Only the commit that actually retires the pending producer may be forwarded;
    // a stale commit (older tag) must not hide a newer rename.
    assign byp_hit = cmt_vld && (cmt_reg != '0) && (cmt_reg == ask_dat) && (st_dep == cmt_rob);

    always_comb begin
        dep_dat   = st_dep;
        value_dat = st_value;
        if (ask_dat == '0) begin
            dep_dat   = ROB_ID_W'(ROB_ID_NONE);
            value_dat = '0;
        end else if (byp_hit) begin
            dep_dat   = ROB_ID_W'(ROB_ID_NONE);
            value_dat = cmt_value;
        end
    end
`else
    logic unused_byp;
    assign unused_byp = ^{cmt_vld, cmt_reg, cmt_rob, cmt_value};

    always_comb begin
        dep_dat   = st_dep;
        value_dat = st_value;
        if (ask_dat == '0) begin
            dep_dat   = ROB_ID_W'(ROB_ID_NONE);
            value_dat = '0;
        end
    end
`endif

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags (x1..x31; x0 hardwired to zero).
// Latency: queries combinational; launch/commit visible on queries the cycle after the edge.
// Backpressure: none; rdy_in low freezes all state, rst_in (sync, active-high) overrides all.
// Ports: clk_in, rst_in, rdy_in scalars; rf = register_file_if.slave (launch/commit/clear/queries).
// Option: REGFILE_COMMIT_BYPASS_EN forwards a matching same-cycle commit to the query ports.
module register_file #(
    parameter int XLEN     = cpu_pkg::XLEN,
    parameter int REG_NUM  = 32,
    parameter int ROB_ID_W = cpu_pkg::ROB_ID_W
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    register_file_if.slave        rf
);
    import cpu_pkg::*;

    logic [XLEN-1:0]     value_q [1:REG_NUM-1];
    logic [XLEN-1:0]     value_d [1:REG_NUM-1];
    logic [ROB_ID_W-1:0] dep_q   [1:REG_NUM-1];
    logic [ROB_ID_W-1:0] dep_d   [1:REG_NUM-1];

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        value_d = value_q;
        dep_d   = dep_q;
        if (rdy_in) begin
            if (rf._rf_commit_ready && (rf._rf_commit_register_id != '0)) begin
                value_d[rf._rf_commit_register_id] = rf._rf_commit_value;
                // Exact tag match only: ids wrap, so a newer rename of the same
                // register must survive the retirement of an older producer.
                if (dep_q[rf._rf_commit_register_id] == rf._rf_commit_rob_id) begin
                    dep_d[rf._rf_commit_register_id] = ROB_ID_W'(ROB_ID_NONE);
                end
            end
            // Applied after the commit so a same-cycle launch wins the tag.
            if (rf._clear) begin
                for (int i = 1; i < REG_NUM; i++) begin
                    dep_d[i] = ROB_ID_W'(ROB_ID_NONE);
                end
            end else if (rf._rf_launch_ready && (rf._rf_launch_register_id != '0)) begin
                dep_d[rf._rf_launch_register_id] = rf._rf_launch_rob_id;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 1; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                dep_q[i]   <= ROB_ID_W'(ROB_ID_NONE);
            end
        end else begin
            value_q <= value_d;
            dep_q   <= dep_d;
        end
    end

    // ------------------------------------------------------------------
    // Query ports
    // ------------------------------------------------------------------
    logic [ROB_ID_W-1:0] st_dep_1, st_dep_2;
    logic [XLEN-1:0]     st_value_1, st_value_2;
    logic                cmt_vld;

    // x0 has no storage; the read port substitutes zeros for it.
    always_comb begin
        st_dep_1   = '0;
        st_value_1 = '0;
        st_dep_2   = '0;
        st_value_2 = '0;
        if (rf._ask_rd_1 != '0) begin
            st_dep_1   = dep_q[rf._ask_rd_1];
            st_value_1 = value_q[rf._ask_rd_1];
        end
        if (rf._ask_rd_2 != '0) begin
            st_dep_2   = dep_q[rf._ask_rd_2];
            st_value_2 = value_q[rf._ask_rd_2];
        end
    end

    // A commit only forwards when it will actually be written this edge.
    assign cmt_vld = rdy_in && !rst_in && rf._rf_commit_ready;

    regfile_read_port #(.XLEN(XLEN), .ROB_ID_W(ROB_ID_W)) u_read_port_1 (
        .ask_dat   (rf._ask_rd_1),
        .st_dep    (st_dep_1),
        .st_value  (st_value_1),
        .cmt_vld   (cmt_vld),
        .cmt_reg   (rf._rf_commit_register_id),
        .cmt_rob   (rf._rf_commit_rob_id),
        .cmt_value (rf._rf_commit_value),
        .dep_dat   (rf._dep_rd_1),
        .value_dat (rf._dep_value_1)
    );

    regfile_read_port #(.XLEN(XLEN), .ROB_ID_W(ROB_ID_W)) u_read_port_2 (
        .ask_dat   (rf._ask_rd_2),
        .st_dep    (st_dep_2),
        .st_value  (st_value_2),
        .cmt_vld   (cmt_vld),
        .cmt_reg   (rf._rf_commit_register_id),
        .cmt_rob   (rf._rf_commit_rob_id),
        .cmt_value (rf._rf_commit_value),
        .dep_dat   (rf._dep_rd_2),
        .value_dat (rf._dep_value_2)
    );

endmodule

// File: doc/register_file.md
# register_file

Architectural register file with per-register rename tags. It sits directly downstream of the reorder buffer: it records which in-flight ROB entry will produce each register at launch, writes committed values at commit, and answers the ROB's two operand-dependency queries each cycle. On a flush it drops all rename tags and keeps the committed values.

## Interface
Parameters:
- XLEN, 32, data width
- REG_NUM, 32, number of architectural registers; x0 is hardwired
- ROB_ID_W, 5, ROB tag width; tag 0 means "no producer", valid ROB ids are 1..31

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  ready; when low, all state holds
- _clear  in  1  pipeline flush from the ROB
- _rf_launch_ready  in  1  rename rd at issue
- _rf_launch_rob_id  in  ROB_ID_W  producing ROB entry
- _rf_launch_register_id  in  5  destination register
- _rf_commit_ready  in  1  retire a write
- _rf_commit_rob_id  in  ROB_ID_W  retiring ROB entry
- _rf_commit_register_id  in  5  destination register
- _rf_commit_value  in  XLEN  committed value
- _ask_rd_1, _ask_rd_2  in  5  source register queries
- _dep_rd_1, _dep_rd_2  out  ROB_ID_W  pending producer tag, 0 if the register is ready
- _dep_value_1, _dep_value_2  out  XLEN  committed register value

## Operation
- State: value[1..31] (XLEN) and dep[1..31] (ROB_ID_W). x0 is not stored. For x0, queries return dep 0 and value 0, and writes to x0 are ignored.
- Query ports are combinational: _dep_rd_k = dep[_ask_rd_k] and _dep_value_k = value[_ask_rd_k].
- Commit, on a clock edge with rdy_in high and register != 0:
  - value[reg] <= commit value.
  - dep[reg] <= 0 only when dep[reg] == _rf_commit_rob_id. A newer rename must never be cleared.
- Launch, on a clock edge with rdy_in high, register != 0 and _clear low: dep[reg] <= _rf_launch_rob_id.
- Same-cycle launch and commit to the same register: launch wins for dep, and commit still writes value.
- _clear high (with rdy_in high): all dep are set to 0 and the launch is dropped. A commit in the same cycle still writes value.
- rst_in has priority over everything, including rdy_in. It sets every value and dep to 0.
- rdy_in low: no state change. Queries still reflect the held state.

## Timing
- Reset values: all _dep_rd_k = 0 and all _dep_value_k = 0 in the cycle after rst_in is sampled high.
- Query latency is 0 cycles, combinational from state.
- Launch and commit effects are visible on the query outputs in the cycle after the edge.
- There is no handshake and no backpressure. Every asserted launch or commit is accepted in its cycle.
- Reset mid-operation discards all renames and values. A launch or commit in the reset cycle is lost.
- Tag wrap-around: the ROB reuses ids 1..31. Correctness relies on the exact-match rule on commit.

## Configuration
- REGFILE_COMMIT_BYPASS_EN
  - Defined: a query whose _ask_rd_k equals a same-cycle _rf_commit_register_id (not 0), with dep matching _rf_commit_rob_id, returns dep 0 and _rf_commit_value combinationally. This saves one cycle of operand wait.
  - Undefined: queries reflect registered state only, and the commit becomes visible one cycle later.
- State update behaviour is identical in both builds.

## Structure
- Shared package cpu_pkg holds:
  - XLEN, ROB_ID_W, REG_ADDR_W = 5
  - ROB_ID_NONE = 0
  - the rob_id_t and reg_addr_t typedefs

  The ROB and reservation station use the same package.
- One sub-module, regfile_read_port, instantiated twice. It contains the x0 and bypass mux for a single query port.

## Test plan
- Reset, then query x5 and x0 -> dep 0 and value 0 on both ports.
- Launch x5 with rob 3, next cycle query x5 -> dep 3. Commit x5/rob 3/0xDEADBEEF -> next cycle dep 0, value 0xDEADBEEF.
- Launch x7/rob 4, then launch x7/rob 9, then commit x7/rob 4/0x11 -> value 0x11 and dep stays 9.
- Same-cycle launch x8/rob 2 and commit x8/rob 1/0x55 (dep was 1) -> dep 2, value 0x55.
- With x3 dep 6, assert _clear together with launch x4/rob 7 and commit x2/rob 5/0x99 -> all deps 0, value[2] = 0x99, x4 not renamed.
- Launch and commit to x0, with rdy_in low for two cycles during a launch -> x0 stays 0, no state change while rdy_in is low. With bypass built in, a same-cycle commit query returns the new value immediately.
